// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - MDU opcode encodings, default latencies and HI/LO select constants
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  localparam logic SEL_LO = 1'b0;
  localparam logic SEL_HI = 1'b1;

  // Ops 0..3 go through the multi-cycle path; everything else completes at once.
  function automatic logic is_arith(input logic [2:0] op);
    return (op <= 3'd3);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// rtl/mdu_arith.sv - combinational multiply/divide datapath producing {HI,LO}
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDUOp,
  output logic [31:0] ResHI,
  output logic [31:0] ResLO,
  output logic        DivZero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        signed_div;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] divisor;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  // Sign-extending to 64 bits makes the truncated 64x64 product the exact signed result.
  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide is done on magnitudes so 0x80000000 / -1 wraps to 0x80000000
  // instead of relying on an overflowing signed division.
  assign signed_div = (MDUOp == MDU_DIV);
  assign a_neg      = signed_div & A[31];
  assign b_neg      = signed_div & B[31];
  assign mag_a      = a_neg ? (32'd0 - A) : A;
  assign mag_b      = b_neg ? (32'd0 - B) : B;
  // A zero divisor never commits; substituting 1 keeps the divider output defined.
  assign divisor    = (B == 32'd0) ? 32'd1 : mag_b;
  assign q_mag      = mag_a / divisor;
  assign r_mag      = mag_a % divisor;
  assign quot       = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem        = a_neg ? (32'd0 - r_mag) : r_mag;

  assign DivZero = is_div(MDUOp) && (B == 32'd0);

  // Select the result pair for the requested op; non-arith ops produce zero.
  always_comb begin
    ResHI = 32'd0;
    ResLO = 32'd0;
    case (MDUOp)
      MDU_MULT:           {ResHI, ResLO} = prod_s;
      MDU_MULTU:          {ResHI, ResLO} = prod_u;
      MDU_DIV, MDU_DIVU:  {ResHI, ResLO} = {rem, quot};
      default:            {ResHI, ResLO} = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// rtl/mdu.sv - multi-cycle multiply/divide unit holding architectural HI/LO
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        ReadSel,
  output logic [31:0] RData,
  output logic        Busy
);

  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_dz;
  logic [3:0]  cnt;

  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        div_zero;

  mdu_arith u_arith (
    .A       (A),
    .B       (B),
    .MDUOp   (MDUOp),
    .ResHI   (res_hi),
    .ResLO   (res_lo),
    .DivZero (div_zero)
  );

  assign Busy  = (cnt != 4'd0);
  assign RData = (ReadSel == SEL_HI) ? hi : lo;

  // Count down an in-flight op and commit on the last cycle; otherwise accept a new Start.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_dz <= 1'b0;
      cnt     <= 4'd0;
    end else if (cnt != 4'd0) begin
      // Any Start arriving here is dropped: the hazard unit is expected to stall it.
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1 && !pend_dz) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end else if (Start) begin
      if (is_arith(MDUOp)) begin
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        pend_dz <= div_zero;
        cnt     <= is_div(MDUOp) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
      end else if (MDUOp == MDU_MTHI) begin
        hi <= A;
      end else if (MDUOp == MDU_MTLO) begin
        lo <= A;
      end
    end
  end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the EX stage of the pipelined MIPS core. Executes MULT, MULTU, DIV, DIVU with fixed multi-cycle latency, holds the architectural HI/LO registers, and services MTHI/MTLO writes and MFHI/MFLO reads. The MFHI/MFLO result travels down the pipeline as the write data of the general register file. Busy is exported to the hazard unit, which stalls ID.

## Interface
- MULT_CYCLES, 5, cycles Busy stays high for MULT/MULTU
- DIV_CYCLES, 10, cycles Busy stays high for DIV/DIVU
- Clk  input  1  clock; all state changes on posedge
- Reset  input  1  synchronous, active-low (0 = reset, sampled on posedge Clk)
- Start  input  1  launch/execute MDUOp this cycle
- MDUOp  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
- A  input  32  rs operand
- B  input  32  rt operand
- ReadSel  input  1  0 selects LO, 1 selects HI
- RData  output  32  current HI or LO per ReadSel
- Busy  output  1  multi-cycle operation in flight

## Operation
- State: HI, LO (32b each), PendHI, PendLO (32b), Cnt (4b), plus a divide-by-zero flag for the pending op (PendDZ). Busy = (Cnt != 0).
- Start with Busy=0 and MDUOp 0-3: compute result from A/B, latch into PendHI/PendLO, load Cnt with MULT_CYCLES or DIV_CYCLES.
- MULT: signed 64b product {HI,LO}. MULTU: unsigned.
- DIV: LO = quotient truncated toward zero, HI = remainder with sign of dividend (A). DIVU: unsigned.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000, no trap.
- Divide by zero (B=0, DIV or DIVU): Busy behaves normally; HI/LO left unchanged at commit.
- MTHI/MTLO with Start, Busy=0: HI (or LO) <= A at that edge; Cnt untouched.
- Start while Busy=1: ignored entirely (hazard unit guarantees stall; the unit does not queue).
- MDUOp 6-7 with Start: no effect.
- Each edge with Cnt != 0: Cnt decrements; on 1->0 transition HI/LO <= PendHI/PendLO (unless PendDZ).
- RData = ReadSel ? HI : LO, combinational from committed registers; no bypass of pending results (reads during Busy are stalled upstream).

## Timing
- Reset (Reset=0 at an edge): HI=LO=0, PendHI=PendLO=0, Cnt=0, Busy=0; RData=0 after that edge. Reset mid-operation aborts it; pending result discarded.
- Start sampled at edge E (cycle T): Busy=1 during cycles T+1 .. T+N (N = MULT_CYCLES/DIV_CYCLES); commit at edge ending T+N; Busy=0 and new HI/LO on RData in cycle T+N+1.
- Start in the first cycle Busy=0 after a commit is accepted (back-to-back, no bubble).
- MTHI/MTLO: visible on RData the cycle after Start.
- Hazard unit must stall on (Start & MDUOp<=3) | Busy for MDU-class instructions in ID.
- Parameters must be 1..15; Cnt width 4.

## Structure
- Package mdu_pkg: MDUOp encodings (MDU_MULT..MDU_MTLO), default latencies, HI/LO select constants.
- One natural sub-module: mdu_arith, purely combinational, inputs A, B, MDUOp; outputs 64b {ResHI,ResLO} and DivZero. mdu owns counter, pending registers, HI/LO.

## Test plan
- Reset then MULT A=0xFFFFFFFF B=0x00000002 -> Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- MULTU A=0xFFFFFFFF B=0x00000002 -> HI=0x00000001, LO=0xFFFFFFFE after 5 Busy cycles.
- DIV A=0xFFFFFFF9 (-7) B=2 -> Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU same operands -> LO=0x7FFFFFFC, HI=0x00000001.
- MTHI A=0x12345678, then DIV B=0 -> Busy 10 cycles, HI stays 0x12345678; also DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MULT started, Start+MTLO A=0xDEAD issued at Busy cycle 2 -> ignored; LO ends as product. Back-to-back MULT issued cycle after Busy falls -> accepted immediately.
- MULT in flight, Reset=0 at Busy cycle 3 -> Busy=0, HI=LO=0 next cycle; no later commit.
